// File: rtl/sevenseg_to_bcdnumber.sv
// Collects n_conv 7-segment patterns, decodes each to a BCD nibble and presents the assembled number.
// Optional build macro SEG_BLANK_AS_ZERO_EN: a blank pattern (all segments off) decodes as digit 0.
module sevenseg_to_bcdnumber #(
  parameter int n_conv = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  output logic [4*n_conv-1:0]   bcd_number,
  output logic                  bcd_valid,
  input  logic                  bcd_ready,
  output logic                  err
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  typedef struct packed {
    logic       bad;
    logic [3:0] nibble;
  } digit_t;

  localparam logic [3:0] LAST_DIGIT = 4'(n_conv - 1);

  state_t               state, state_next;
  logic [3:0]           digit_cnt;
  logic [4*n_conv-1:0]  shift_reg;
  logic                 err_flag;
  logic                 transfer;
  logic                 last_digit;
  logic                 handoff;
  digit_t               decoded;
  logic [4*n_conv+3:0]  shifted;

  // dp (bit 7) never takes part in the decode.
  function automatic digit_t decode_seg(input logic [6:0] seg);
    digit_t d;
    d.bad    = 1'b0;
    d.nibble = 4'hF;
    case (seg)
      7'h3F:   d.nibble = 4'd0;
      7'h06:   d.nibble = 4'd1;
      7'h5B:   d.nibble = 4'd2;
      7'h4F:   d.nibble = 4'd3;
      7'h66:   d.nibble = 4'd4;
      7'h6D:   d.nibble = 4'd5;
      7'h7D:   d.nibble = 4'd6;
      7'h07:   d.nibble = 4'd7;
      7'h7F:   d.nibble = 4'd8;
      7'h6F:   d.nibble = 4'd9;
`ifdef SEG_BLANK_AS_ZERO_EN
      7'h00:   d.nibble = 4'd0;
`else
      7'h00:   d.bad    = 1'b1;
`endif
      default: d.bad    = 1'b1;
    endcase
    return d;
  endfunction

  assign decoded    = decode_seg(seg_in[6:0]);
  assign transfer   = seg_valid && seg_ready;
  assign last_digit = (digit_cnt == LAST_DIGIT);
  assign handoff    = bcd_valid && bcd_ready;
  // Earlier digits move up one nibble; the newest lands in the low nibble.
  assign shifted    = {shift_reg, decoded.nibble};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    seg_ready  = 1'b0;
    bcd_valid  = 1'b0;
    case (state)
      COLLECT: begin
        seg_ready = 1'b1;
        if (transfer && last_digit) state_next = HOLD;
      end
      HOLD: begin
        bcd_valid = 1'b1;
        if (bcd_ready) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      digit_cnt <= '0;
      shift_reg <= '0;
      err_flag  <= 1'b0;
    end else begin
      state <= state_next;
      if (transfer) begin
        shift_reg <= shifted[4*n_conv-1:0];
        digit_cnt <= last_digit ? 4'd0 : digit_cnt + 4'd1;
        if (decoded.bad) err_flag <= 1'b1;
      end
      // The number stays on bcd_number after handoff; only the error flag starts fresh.
      if (handoff) err_flag <= 1'b0;
    end
  end

  assign bcd_number = shift_reg;
  assign err        = err_flag;

endmodule

// File: tb/tb_sevenseg_to_bcdnumber.sv
// Directed self-checking bench for sevenseg_to_bcdnumber with two digits per number.
module tb_sevenseg_to_bcdnumber;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic        seg_valid;
  logic        seg_ready;
  logic [7:0]  bcd_number;
  logic        bcd_valid;
  logic        bcd_ready;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  sevenseg_to_bcdnumber #(.n_conv(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .bcd_number (bcd_number),
    .bcd_valid  (bcd_valid),
    .bcd_ready  (bcd_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      default: return 8'h6F;
    endcase
  endfunction

  // Drives two consecutive transfers; returns at the falling edge after the last one.
  task automatic send_pair(input logic [7:0] p1, input logic [7:0] p2);
    @(negedge clk);
    seg_in = p1; seg_valid = 1'b1;
    @(negedge clk);
    seg_in = p2;
    @(negedge clk);
    seg_valid = 1'b0;
  endtask

  task automatic handoff();
    bcd_ready = 1'b1;
    @(negedge clk);
    bcd_ready = 1'b0;
  endtask

  task automatic expect_number(input string name, input logic [7:0] num, input logic e);
    vectors++;
    if (bcd_valid !== 1'b1 || bcd_number !== num || err !== e) begin
      miscompares++;
      $display("FAIL %s: got valid=%b number=%h err=%b, need valid=1 number=%h err=%b",
               name, bcd_valid, bcd_number, err, num, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; seg_valid = 1'b0; seg_in = 8'h00; bcd_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (seg_ready !== 1'b1 || bcd_valid !== 1'b0 || bcd_number !== 8'h00 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got ready=%b valid=%b number=%h err=%b, need 1 0 00 0",
               seg_ready, bcd_valid, bcd_number, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_pair(8'h4F, 8'h66);
    expect_number("basic_34", 8'h34, 1'b0);
    handoff();
    vectors++;
    if (seg_ready !== 1'b1 || bcd_valid !== 1'b0 || bcd_number !== 8'h34) begin
      miscompares++;
      $display("FAIL basic_handoff: got ready=%b valid=%b number=%h, need 1 0 34",
               seg_ready, bcd_valid, bcd_number);
    end
  endtask

  task automatic test_error();
    send_pair(8'h7F, 8'h12);
    expect_number("error_8F", 8'h8F, 1'b1);
    handoff();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL error_clear: got err=%b, need 0", err);
    end
    // dp set on a valid digit must not count as an error.
    send_pair(8'hBF, 8'h06);
    expect_number("error_next_01", 8'h01, 1'b0);
    handoff();
  endtask

  task automatic test_hold_stall();
    send_pair(enc(6), enc(2));
    seg_valid = 1'b1; seg_in = enc(9);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (seg_ready !== 1'b0 || bcd_valid !== 1'b1 || bcd_number !== 8'h62) begin
        miscompares++;
        $display("FAIL stall_%0d: got ready=%b valid=%b number=%h, need 0 1 62",
                 i, seg_ready, bcd_valid, bcd_number);
      end
      @(negedge clk);
    end
    seg_valid = 1'b0;
    handoff();
    vectors++;
    if (seg_ready !== 1'b1 || bcd_valid !== 1'b0 || bcd_number !== 8'h62) begin
      miscompares++;
      $display("FAIL stall_release: got ready=%b valid=%b number=%h, need 1 0 62",
               seg_ready, bcd_valid, bcd_number);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    seg_in = 8'h6D; seg_valid = 1'b1;
    @(negedge clk);
    seg_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bcd_number !== 8'h00 || seg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_clear: got number=%h ready=%b, need 00 1", bcd_number, seg_ready);
    end
    send_pair(8'h07, 8'h6F);
    expect_number("reset_mid_79", 8'h79, 1'b0);
    // Reset in HOLD drops the number; reset also beats a simultaneous transfer.
    rst = 1'b1; seg_valid = 1'b1; seg_in = enc(2);
    @(negedge clk);
    rst = 1'b0; seg_valid = 1'b0;
    vectors++;
    if (bcd_valid !== 1'b0 || bcd_number !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold: got valid=%b number=%h, need 0 00", bcd_valid, bcd_number);
    end
    send_pair(enc(4), enc(7));
    expect_number("reset_priority_47", 8'h47, 1'b0);
    handoff();
  endtask

  task automatic test_ready_in_collect();
    // bcd_ready held high through the first digit must not disturb collection.
    @(negedge clk);
    bcd_ready = 1'b1; seg_in = enc(5); seg_valid = 1'b1;
    @(negedge clk);
    bcd_ready = 1'b0; seg_in = enc(8);
    @(negedge clk);
    seg_valid = 1'b0;
    expect_number("ready_collect_58", 8'h58, 1'b0);
    handoff();
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    for (int k = 0; k < 100; k++) begin
      want = {4'(k / 10), 4'(k % 10)};
      send_pair(enc(k / 10), enc(k % 10));
      expect_number($sformatf("sweep_%0d", k), want, 1'b0);
      handoff();
    end
  endtask

  task automatic test_blank();
    send_pair(8'h00, 8'h3F);
`ifdef SEG_BLANK_AS_ZERO_EN
    expect_number("blank_00", 8'h00, 1'b0);
`else
    expect_number("blank_F0", 8'hF0, 1'b1);
`endif
    handoff();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_hold_stall();
    test_reset_mid();
    test_ready_in_collect();
    test_back_to_back();
    test_blank();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sevenseg_to_bcdnumber.md
SEVENSEG_TO_BCDNUMBER -- requirements
Module: sevenseg_to_bcdnumber

Interface
REQ-001 SHALL have parameter n_conv, default 4, giving the number of digits per assembled BCD number (range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port seg_in, input, 8 bits: one 7-segment pattern. Bit 0 = a, bits 1-6 = b-g, bit 7 = dp. 1 = segment lit.
REQ-005 SHALL have port seg_valid, input, 1 bit: seg_in holds a digit pattern this cycle.
REQ-006 SHALL have port seg_ready, output, 1 bit: block accepts a pattern this cycle.
REQ-007 SHALL have port bcd_number, output, 4*n_conv bits: the assembled BCD number, most significant digit in the top nibble.
REQ-008 SHALL have port bcd_valid, output, 1 bit: bcd_number and err are complete and stable.
REQ-009 SHALL have port bcd_ready, input, 1 bit: consumer takes bcd_number this cycle.
REQ-010 SHALL have port err, output, 1 bit: at least one pattern in the current number was invalid.

Function
REQ-011 SHALL decode the low 7 bits of each pattern as follows (hex, dp ignored): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
REQ-012 SHALL treat any other 7-bit value as invalid: the stored nibble = 4'hF and the error flag for the current number is set.
REQ-013 SHALL accept a pattern only on a cycle where seg_valid=1 and seg_ready=1 (the transfer cycle).
REQ-014 SHALL use two FSM states, COLLECT and HOLD; the reset state is COLLECT.
REQ-015 In COLLECT, SHALL drive seg_ready=1 and bcd_valid=0.
REQ-016 In COLLECT, on each transfer SHALL shift the decoded nibble into the low nibble of the shift register (earlier digits move up one nibble) and increment the digit counter.
REQ-017 On the transfer of digit n_conv, SHALL move to HOLD on the next edge. bcd_valid SHALL rise on the cycle after that last transfer (latency 1 cycle), and the counter SHALL wrap to 0.
REQ-018 In HOLD, SHALL drive seg_ready=0 and bcd_valid=1, and SHALL keep bcd_number and err constant until handoff.
REQ-019 In HOLD with bcd_ready=1, SHALL return to COLLECT on the next edge and clear the error flag; bcd_number SHALL keep its last value until overwritten by shifting.
REQ-020 seg_valid during HOLD SHALL be ignored; no data is lost, because seg_ready=0.
REQ-021 bcd_ready asserted during COLLECT SHALL have no effect.
REQ-022 The err output SHALL be the OR of invalid flags for all digits of the current number. It is sticky within the number and visible with bcd_valid.
REQ-023 bcd_valid SHALL NOT drop in HOLD without a handoff (bcd_ready=1).

Reset
REQ-024 With rst=1 at a clock edge, SHALL force: state=COLLECT, digit counter=0, bcd_number=0, err=0, bcd_valid=0, seg_ready=1 from the next cycle.
REQ-025 A reset mid-number SHALL discard all partially collected digits; a reset in HOLD SHALL drop the pending number without handoff.
REQ-026 rst SHALL take priority over any simultaneous transfer or handoff.

Configuration
REQ-027 Macro SEG_BLANK_AS_ZERO_EN, when defined, SHALL decode pattern 7'h00 (all segments off) as digit 0 without setting err.
REQ-028 Without SEG_BLANK_AS_ZERO_EN, 7'h00 SHALL be invalid per REQ-012.

Verification (n_conv=2)
REQ-029 Send patterns 4F then 66 with continuous valid -> one cycle later bcd_valid=1, bcd_number=8'h34, err=0.
REQ-030 Send 7F then 12 -> bcd_number=8'h8F, err=1; the next number (3F, 06) -> 8'h01, err=0.
REQ-031 Hold bcd_ready=0 for 5 cycles in HOLD while seg_valid=1 -> seg_ready=0 throughout and bcd_number stable; then one cycle of bcd_ready=1 -> COLLECT, seg_ready=1.
REQ-032 Send 6D, then assert rst, then send 07, 6F -> bcd_number=8'h79; the 5 is not present.
REQ-033 Loop k=0..99, sending the encoder patterns of the tens and units digits of k -> bcd_number equals the BCD of k each time, err=0.
REQ-034 Send pattern 00 then 3F -> 8'h00 with err=0 under SEG_BLANK_AS_ZERO_EN; 8'hF0 with err=1 without it.
